trim_rx: RTL and testbench



---
 rtl/trim_rx.sv | 144 ++++++++++++++
 tb/tb_trim_rx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trim_rx.sv
// trim_rx: receive end of the serial trim link. Deserializes LSB-first DIN bits,
// sampled on ENCLK falling edges, into TRIMCODE; an idle timeout closes each frame.
module trim_rx #(
    parameter int WIDTH   = 12,
    parameter int TIMEOUT = 60000000,
    parameter int TCW     = 26
) (
    input  logic             CLK50,
    input  logic             RST_N,
    input  logic             ENCLK,
    input  logic             DIN,
    output logic [WIDTH-1:0] TRIMCODE,
    output logic             VALID,
    output logic             FRAME_ERR,
    output logic             OVERRUN,
    output logic             BUSY
);

    localparam int BW = $clog2(WIDTH + 2);
    localparam logic [BW-1:0]    BIT_ONE = BW'(1);
    localparam logic [BW-1:0]    BIT_W   = BW'(WIDTH);
    localparam logic [BW-1:0]    BIT_OVR = BW'(WIDTH + 1);
    localparam logic [TCW-1:0]   T_ONE   = TCW'(1);
    localparam logic [TCW-1:0]   T_LAST  = TCW'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] SH_ONE  = WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;

    logic en_s1_q, en_s2_q, en_h_q;
    logic din_s1_q, din_s2_q;
    logic fe;

    state_t           state_q, state_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [TCW-1:0]   tcnt_q, tcnt_d;
    logic [WIDTH-1:0] trim_q, trim_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;

    // Two-flop synchronizers; the extra ENCLK flop gives the edge history.
    always_ff @(posedge CLK50 or negedge RST_N) begin
        if (!RST_N) begin
            en_s1_q  <= 1'b0;
            en_s2_q  <= 1'b0;
            en_h_q   <= 1'b0;
            din_s1_q <= 1'b0;
            din_s2_q <= 1'b0;
        end else begin
            en_s1_q  <= ENCLK;
            en_s2_q  <= en_s1_q;
            en_h_q   <= en_s2_q;
            din_s1_q <= DIN;
            din_s2_q <= din_s1_q;
        end
    end

    assign fe = en_h_q & ~en_s2_q;

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        tcnt_d   = tcnt_q;
        trim_d   = trim_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                bitcnt_d = '0;
                shreg_d  = '0;
                tcnt_d   = '0;
                if (fe) begin
                    state_d  = S_RECV;
                    shreg_d  = {{(WIDTH-1){1'b0}}, din_s2_q};
                    bitcnt_d = BIT_ONE;
                end
            end
            S_RECV: begin
                if (fe) begin
                    if (bitcnt_q < BIT_W) begin
                        shreg_d = (shreg_q & ~(SH_ONE << bitcnt_q))
                                | (WIDTH'(din_s2_q) << bitcnt_q);
                    end
                    // Saturating at WIDTH+1 is enough to flag an overrun.
                    if (bitcnt_q != BIT_OVR) begin
                        bitcnt_d = bitcnt_q + BIT_ONE;
                    end
                    tcnt_d = '0;
                end else if (en_s2_q) begin
                    tcnt_d = '0;
                end else if (tcnt_q == T_LAST) begin
                    state_d = S_DONE;
                    if (bitcnt_q >= BIT_W) begin
                        trim_d  = shreg_q;
                        valid_d = 1'b1;
                        ovr_d   = (bitcnt_q == BIT_OVR);
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    tcnt_d = tcnt_q + T_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK50 or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            tcnt_q   <= '0;
            trim_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            tcnt_q   <= tcnt_d;
            trim_q   <= trim_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    assign TRIMCODE  = trim_q;
    assign VALID     = valid_q;
    assign FRAME_ERR = ferr_q;
    assign OVERRUN   = ovr_q;
    assign BUSY      = (state_q == S_RECV);

endmodule

// File: tb/tb_trim_rx.sv
// Self-checking bench for trim_rx: directed scenarios plus randomized frames
// compared against a frame-level model of the trim link.
module tb_trim_rx;

    localparam int WIDTH   = 12;
    localparam int TIMEOUT = 16;
    localparam int TCW     = 5;
    localparam int LAT     = TIMEOUT + 3;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             enclk = 1'b0;
    logic             din   = 1'b0;
    logic [WIDTH-1:0] trimcode;
    logic             valid, ferr, ovr, busy;

    int vectors    = 0;
    int miscompares = 0;
    int n_valid = 0, n_ferr = 0, n_ovr = 0, n_ovr_alone = 0;
    logic [WIDTH-1:0] exp_trim = '0;
    logic             busy_long = 1'b0;

    trim_rx #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .TCW(TCW)) dut (
        .CLK50(clk), .RST_N(rst_n), .ENCLK(enclk), .DIN(din),
        .TRIMCODE(trimcode), .VALID(valid), .FRAME_ERR(ferr),
        .OVERRUN(ovr), .BUSY(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) n_valid <= n_valid + 1;
        if (ferr) n_ferr <= n_ferr + 1;
        if (ovr) n_ovr <= n_ovr + 1;
        if (ovr && !valid) n_ovr_alone <= n_ovr_alone + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Frame-level reference: a frame with at least WIDTH bits loads its first
    // WIDTH bits; a short frame leaves the register untouched.
    function automatic logic [WIDTH-1:0] model_trim(input logic [WIDTH-1:0] prev,
                                                    input logic [15:0] data, input int n);
        return (n >= WIDTH) ? data[WIDTH-1:0] : prev;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One ENCLK pulse per bit; returns right after the last falling edge.
    task automatic send_bits(input logic [15:0] data, input int n, input int hp,
                             input int long_idx, input int long_hi);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            din   = data[i];
            enclk = 1'b1;
            cyc((i == long_idx) ? long_hi : hp);
            if (i == long_idx) busy_long = busy;
            enclk = 1'b0;
            if (i != n - 1) cyc(hp - 1);
        end
    endtask

    // Cycles from the last ENCLK fall to the end-of-frame pulse (-1 if none).
    task automatic wait_end(output int lat, output logic [WIDTH-1:0] trim_at,
                            output logic busy_at);
        lat = -1;
        trim_at = '0;
        busy_at = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (valid || ferr) begin
                lat = c;
                trim_at = trimcode;
                busy_at = busy;
                break;
            end
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(3);
        vectors++; if (trimcode !== '0) begin miscompares++; $display("FAIL reset_trimcode got %h want 000", trimcode); end
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", valid); end
        vectors++; if (ferr !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err got %b want 0", ferr); end
        vectors++; if (ovr !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b want 0", ovr); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(3);
    endtask

    task automatic test_basic();
        int v0, f0, o0, lat;
        logic [WIDTH-1:0] ta;
        logic ba;
        v0 = n_valid; f0 = n_ferr; o0 = n_ovr;
        send_bits(16'h0A5C, 12, 8, -1, 0);
        wait_end(lat, ta, ba);
        exp_trim = model_trim(exp_trim, 16'h0A5C, 12);
        vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL basic_latency got %0d want %0d", lat, LAT); end
        vectors++; if (ta !== exp_trim) begin miscompares++; $display("FAIL basic_trim_at_valid got %h want %h", ta, exp_trim); end
        vectors++; if (ba !== 1'b0) begin miscompares++; $display("FAIL basic_busy_at_valid got %b want 0", ba); end
        vectors++; if (n_valid - v0 !== 1) begin miscompares++; $display("FAIL basic_valid_count got %0d want 1", n_valid - v0); end
        vectors++; if (n_ferr - f0 !== 0) begin miscompares++; $display("FAIL basic_ferr_count got %0d want 0", n_ferr - f0); end
        vectors++; if (n_ovr - o0 !== 0) begin miscompares++; $display("FAIL basic_ovr_count got %0d want 0", n_ovr - o0); end
        vectors++; if (trimcode !== exp_trim) begin miscompares++; $display("FAIL basic_trimcode got %h want %h", trimcode, exp_trim); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after got %b want 0", busy); end
    endtask

    task automatic test_overrun();
        int v0, o0, a0, lat;
        logic [WIDTH-1:0] ta;
        logic ba;
        v0 = n_valid; o0 = n_ovr; a0 = n_ovr_alone;
        send_bits(16'h33F1, 14, 8, -1, 0);
        wait_end(lat, ta, ba);
        exp_trim = model_trim(exp_trim, 16'h33F1, 14);
        vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL ovr_latency got %0d want %0d", lat, LAT); end
        vectors++; if (n_valid - v0 !== 1) begin miscompares++; $display("FAIL ovr_valid_count got %0d want 1", n_valid - v0); end
        vectors++; if (n_ovr - o0 !== 1) begin miscompares++; $display("FAIL ovr_overrun_count got %0d want 1", n_ovr - o0); end
        vectors++; if (n_ovr_alone - a0 !== 0) begin miscompares++; $display("FAIL ovr_not_with_valid got %0d want 0", n_ovr_alone - a0); end
        vectors++; if (trimcode !== 12'h3F1) begin miscompares++; $display("FAIL ovr_trimcode got %h want 3f1", trimcode); end
    endtask

    task automatic test_short();
        int v0, f0, lat;
        logic [WIDTH-1:0] ta;
        logic ba;
        send_bits(16'h0123, 12, 8, -1, 0);
        wait_end(lat, ta, ba);
        exp_trim = model_trim(exp_trim, 16'h0123, 12);
        v0 = n_valid; f0 = n_ferr;
        send_bits(16'h07FF, 11, 8, -1, 0);
        wait_end(lat, ta, ba);
        exp_trim = model_trim(exp_trim, 16'h07FF, 11);
        vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL short_latency got %0d want %0d", lat, LAT); end
        vectors++; if (n_ferr - f0 !== 1) begin miscompares++; $display("FAIL short_ferr_count got %0d want 1", n_ferr - f0); end
        vectors++; if (n_valid - v0 !== 0) begin miscompares++; $display("FAIL short_valid_count got %0d want 0", n_valid - v0); end
        vectors++; if (trimcode !== 12'h123) begin miscompares++; $display("FAIL short_trimcode got %h want 123", trimcode); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL short_busy_after got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int v0, f0, lat;
        logic [WIDTH-1:0] ta;
        logic ba;
        v0 = n_valid; f0 = n_ferr;
        send_bits(16'h0FFF, 12, 8, -1, 0);
        cyc(24);
        send_bits(16'h0000, 12, 8, -1, 0);
        wait_end(lat, ta, ba);
        exp_trim = model_trim(model_trim(exp_trim, 16'h0FFF, 12), 16'h0000, 12);
        vectors++; if (n_valid - v0 !== 2) begin miscompares++; $display("FAIL b2b_valid_count got %0d want 2", n_valid - v0); end
        vectors++; if (n_ferr - f0 !== 0) begin miscompares++; $display("FAIL b2b_ferr_count got %0d want 0", n_ferr - f0); end
        vectors++; if (trimcode !== exp_trim) begin miscompares++; $display("FAIL b2b_trimcode got %h want %h", trimcode, exp_trim); end
        vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_reset_midframe();
        int v0, lat;
        logic [WIDTH-1:0] ta;
        logic ba;
        send_bits(16'h06B7, 12, 8, -1, 0);
        wait_end(lat, ta, ba);
        exp_trim = model_trim(exp_trim, 16'h06B7, 12);
        vectors++; if (trimcode !== 12'h6B7) begin miscompares++; $display("FAIL rst_pre_trimcode got %h want 6b7", trimcode); end
        send_bits(16'h003F, 6, 8, -1, 0);
        cyc(2);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_busy_midframe got %b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        exp_trim = '0;
        vectors++; if (trimcode !== exp_trim) begin miscompares++; $display("FAIL rst_async_trimcode got %h want 000", trimcode); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_async_busy got %b want 0", busy); end
        cyc(3);
        rst_n = 1'b1;
        cyc(3);
        v0 = n_valid;
        send_bits(16'h0801, 12, 8, -1, 0);
        wait_end(lat, ta, ba);
        exp_trim = model_trim(exp_trim, 16'h0801, 12);
        vectors++; if (n_valid - v0 !== 1) begin miscompares++; $display("FAIL rst_post_valid_count got %0d want 1", n_valid - v0); end
        vectors++; if (trimcode !== 12'h801) begin miscompares++; $display("FAIL rst_post_trimcode got %h want 801", trimcode); end
        vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL rst_post_latency got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_stuck_high();
        int v0, f0, lat;
        logic [WIDTH-1:0] ta;
        logic ba;
        v0 = n_valid; f0 = n_ferr;
        send_bits(16'h05A5, 12, 8, 5, 100);
        #1;
        vectors++; if (busy_long !== 1'b1) begin miscompares++; $display("FAIL stuck_busy got %b want 1", busy_long); end
        vectors++; if (n_valid - v0 + n_ferr - f0 !== 0) begin miscompares++; $display("FAIL stuck_premature_end got %0d pulses want 0", n_valid - v0 + n_ferr - f0); end
        wait_end(lat, ta, ba);
        exp_trim = model_trim(exp_trim, 16'h05A5, 12);
        vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL stuck_latency got %0d want %0d", lat, LAT); end
        vectors++; if (n_valid - v0 !== 1) begin miscompares++; $display("FAIL stuck_valid_count got %0d want 1", n_valid - v0); end
        vectors++; if (trimcode !== 12'h5A5) begin miscompares++; $display("FAIL stuck_trimcode got %h want 5a5", trimcode); end
    endtask

    task automatic test_random();
        int v0, f0, o0, lat, n, hp;
        logic [15:0] data;
        logic [WIDTH-1:0] ta;
        logic ba;
        for (int k = 0; k < 20; k++) begin
            data = 16'($urandom_range(0, 65535));
            n    = $urandom_range(9, 15);
            hp   = $urandom_range(3, 10);
            v0 = n_valid; f0 = n_ferr; o0 = n_ovr;
            send_bits(data, n, hp, -1, 0);
            wait_end(lat, ta, ba);
            exp_trim = model_trim(exp_trim, data, n);
            vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL rand%0d_latency got %0d want %0d", k, lat, LAT); end
            vectors++; if (n_valid - v0 !== ((n >= WIDTH) ? 1 : 0)) begin miscompares++; $display("FAIL rand%0d_valid_count got %0d n=%0d", k, n_valid - v0, n); end
            vectors++; if (n_ferr - f0 !== ((n < WIDTH) ? 1 : 0)) begin miscompares++; $display("FAIL rand%0d_ferr_count got %0d n=%0d", k, n_ferr - f0, n); end
            vectors++; if (n_ovr - o0 !== ((n > WIDTH) ? 1 : 0)) begin miscompares++; $display("FAIL rand%0d_ovr_count got %0d n=%0d", k, n_ovr - o0, n); end
            vectors++; if (trimcode !== exp_trim) begin miscompares++; $display("FAIL rand%0d_trimcode got %h want %h", k, trimcode, exp_trim); end
            cyc($urandom_range(0, 8));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_short();
        test_back_to_back();
        test_reset_midframe();
        test_stuck_high();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
